// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter for the single register-file write port.
// N_REQ requesters use a valid/ready handshake. A requester can hold the grant
// across consecutive transfers (burst lock) for at most LOCK_MAX transfers.
// The winning address/data go through one registered stage that drives the RF.
// Optional feature macro RF_ARB_PRIO_EN: requester 0 gets strict priority in
// ARB; the other requesters share round-robin. A locked owner is never pre-empted.
module rf_write_arbiter #(
  parameter  int N_REQ    = 3,
  parameter  int LOCK_MAX = 8,
  localparam int GW       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_lock,
  input  logic [3*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 RF_w_en,
  output logic [2:0]           w_addr,
  output logic [7:0]           w_data,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   rr_ptr, rr_ptr_nx;
  logic [GW-1:0]   owner, owner_nx;
  logic [7:0]      lock_cnt, lock_cnt_nx;
  logic [GW-1:0]   win_id, xfer_id;
  logic            win_found, xfer;
  logic [GW:0]     sum;
  logic [GW-1:0]   idx;
  logic [2:0]      sel_addr;
  logic [7:0]      sel_data;

  // Successor id, wrapping at N_REQ so non-power-of-2 counts never overflow
  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] id);
    if (id == GW'(N_REQ - 1)) return '0;
    else                      return id + GW'(1);
  endfunction

  // State, pointer, lock counter and registered RF write stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
      RF_w_en  <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      owner    <= owner_nx;
      lock_cnt <= lock_cnt_nx;
      if (xfer) begin
        RF_w_en  <= (sel_addr != 3'd0);
        w_addr   <= sel_addr;
        w_data   <= sel_data;
        grant_id <= xfer_id;
      end else begin
        RF_w_en  <= 1'b0;
      end
    end
  end

  // Next-state: transfer detection, operand select, pointer and lock bookkeeping
  always_comb begin
    xfer        = |(req_valid & req_ready);
    xfer_id     = (state == LOCKED) ? owner : win_id;
    sel_addr    = '0;
    sel_data    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (xfer_id == GW'(i)) begin
        sel_addr = req_addr[3*i +: 3];
        sel_data = req_data[8*i +: 8];
      end
    end
    state_nx    = state;
    rr_ptr_nx   = rr_ptr;
    owner_nx    = owner;
    lock_cnt_nx = lock_cnt;
    if (xfer) rr_ptr_nx = next_ptr(xfer_id);
    case (state)
      ARB: begin
        // A lock limit of one means the first transfer already exhausts it
        if (xfer && req_lock[xfer_id] && (LOCK_MAX > 1)) begin
          state_nx    = LOCKED;
          owner_nx    = xfer_id;
          lock_cnt_nx = 8'd1;
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (req_lock[owner]) begin
            if (lock_cnt + 8'd1 == 8'(LOCK_MAX)) begin
              state_nx    = ARB;
              lock_cnt_nx = '0;
            end else begin
              lock_cnt_nx = lock_cnt + 8'd1;
            end
          end else begin
            state_nx    = ARB;
            lock_cnt_nx = '0;
          end
        end else if (!req_lock[owner]) begin
          state_nx    = ARB;
          lock_cnt_nx = '0;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  // Outputs: winner search from rr_ptr and the ready vector
  always_comb begin
    req_ready = '0;
    win_found = 1'b0;
    win_id    = '0;
    sum       = '0;
    idx       = '0;
    if (state == LOCKED) begin
      req_ready[owner] = 1'b1;
    end else begin
`ifdef RF_ARB_PRIO_EN
      if (req_valid[0]) win_found = 1'b1;
`endif
      // With requester 0 idle the rotating scan skips it naturally
      for (int unsigned k = 0; k < N_REQ; k++) begin
        sum = {1'b0, rr_ptr} + (GW+1)'(k);
        if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
        idx = sum[GW-1:0];
        if (!win_found && req_valid[idx]) begin
          win_found = 1'b1;
          win_id    = idx;
        end
      end
      if (win_found) req_ready[win_id] = 1'b1;
    end
    busy = (state == LOCKED);
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios followed by random traffic.
// Expected post-edge outputs go into a queue; a monitor pops and compares them.
module tb_rf_write_arbiter;
  localparam int N  = 3;
  localparam int LM = 8;
  localparam int GW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0, req_lock = '0;
  logic [3*N-1:0]   req_addr = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             RF_w_en;
  logic [2:0]       w_addr;
  logic [7:0]       w_data;
  logic [GW-1:0]    grant_id;
  logic             busy;

  rf_write_arbiter #(.N_REQ(N), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .RF_w_en(RF_w_en), .w_addr(w_addr), .w_data(w_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       en;
    bit [2:0] addr;
    bit [7:0] data;
    int       gid;
    bit       busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state
  bit       m_locked = 0;
  int       m_owner = 0, m_cnt = 0, m_rr = 0;
  bit [2:0] m_addr = 0;
  bit [7:0] m_data = 0;
  int       m_gid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who the arbitration rules select when unlocked; -1 if nobody is asking
  function automatic int pick(input logic [N-1:0] v);
`ifdef RF_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  // One cycle: drive at negedge, check ready, predict post-edge outputs
  task automatic cycle(input bit r, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [3*N-1:0] a, input logic [8*N-1:0] d);
    int w, id;
    logic [N-1:0] er;
    exp_t e;
    @(negedge clk);
    rst = r; req_valid = v; req_lock = l; req_addr = a; req_data = d;
    w = pick(v);
    er = '0;
    if (m_locked) er[m_owner] = 1'b1;
    else if (w >= 0) er[w] = 1'b1;
    #1;
    check("req_ready", 32'(req_ready), 32'(er));
    e.en = 0;
    if (r) begin
      m_locked = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
      m_addr = 0; m_data = 0; m_gid = 0;
    end else begin
      id = -1;
      if (!m_locked) id = w;
      else if (v[m_owner]) id = m_owner;
      else if (!l[m_owner]) m_locked = 0;
      if (id >= 0) begin
        m_addr = a[3*id +: 3];
        m_data = d[8*id +: 8];
        m_gid  = id;
        e.en   = (m_addr != 0);
        m_rr   = (id + 1) % N;
        if (m_locked) begin
          if (l[id]) begin
            m_cnt++;
            if (m_cnt == LM) m_locked = 0;
          end else m_locked = 0;
        end else if (l[id] && LM > 1) begin
          m_locked = 1; m_owner = id; m_cnt = 1;
        end
      end
    end
    e.addr = m_addr; e.data = m_data; e.gid = m_gid; e.busy = m_locked;
    q.push_back(e);
  endtask

  // Monitor: compare registered outputs one step after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("RF_w_en",  32'(RF_w_en),  32'(e.en));
        check("w_addr",   32'(w_addr),   32'(e.addr));
        check("w_data",   32'(w_data),   32'(e.data));
        check("grant_id", 32'(grant_id), 32'(e.gid));
        check("busy",     32'(busy),     32'(e.busy));
      end
    end
  end

  localparam logic [3*N-1:0] A123 = {3'd3, 3'd2, 3'd1};
  localparam logic [8*N-1:0] DABC = {8'hC3, 8'hB2, 8'hA1};

  initial begin
    logic [N-1:0]   v, l;
    logic [3*N-1:0] a;
    logic [8*N-1:0] d;
    // Reset held with every requester active
    repeat (2) cycle(1, '1, '0, A123, DABC);
    // Round-robin fairness with all requesters valid
    repeat (9) cycle(0, '1, '0, A123, DABC);
    // Address 0 handshake without an RF write
    cycle(0, 3'b010, '0, {3'd0, 3'd0, 3'd0}, {8'h00, 8'hFF, 8'h00});
    cycle(0, '0, '0, A123, DABC);
    // Requester 2 bursts three locked transfers then a final one, requester 0 waiting
    cycle(1, '0, '0, A123, DABC);
    cycle(0, 3'b001, '0, A123, DABC);            // rr_ptr -> 1
    cycle(0, 3'b001, '0, A123, DABC);            // rr_ptr stays behind 2 after this
    cycle(0, 3'b101, 3'b100, A123, DABC);
    repeat (2) cycle(0, 3'b101, 3'b100, A123, DABC);
    cycle(0, 3'b101, 3'b000, A123, DABC);
    repeat (2) cycle(0, 3'b101, 3'b000, A123, DABC);
    // Owner idle but holding lock, then reset in the middle of the lock
    cycle(0, 3'b010, 3'b010, A123, DABC);
    cycle(0, 3'b000, 3'b010, A123, DABC);
    cycle(1, 3'b011, 3'b010, A123, DABC);
    cycle(0, 3'b011, 3'b000, A123, DABC);
    // Requesters 0 and 1 continuously valid
    repeat (6) cycle(0, 3'b011, '0, A123, DABC);
    // Random traffic; heavy lock phases reach the forced release
    for (int i = 0; i < 3000; i++) begin
      v = N'($urandom);
      if (i % 600 < 300) l = '1 ^ N'($urandom_range(0, 7) == 0 ? $urandom : 0);
      else l = N'($urandom);
      if (i % 600 < 300) v = v | N'($urandom_range(0, 3) != 0 ? '1 : 0);
      a = (3*N)'($urandom);
      d = (8*N)'({$urandom, $urandom});
      cycle($urandom_range(0, 199) == 0, v, l, a, d);
    end
    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
